// File: rtl/display_msg_sel_if.sv
// Signal bundle between the UART/baud sources, display_msg_sel and the digit display.
// master = source/display side (testbench), slave = display_msg_sel.
interface display_msg_sel_if;
  logic [1:0] baud_sel;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       mode;
  logic [7:0] msg;
  logic [1:0] show_src;

  modport master (
    output baud_sel, rx_valid, rx_data, tx_start, tx_data,
    input  mode, msg, show_src
  );

  modport slave (
    input  baud_sel, rx_valid, rx_data, tx_start, tx_data,
    output mode, msg, show_src
  );
endinterface

// File: rtl/display_msg_sel.sv
// Chooses what the seven-segment stage shows: the baud code, or a UART byte held for HOLD_CYCLES.
// Define DISP_TX_ECHO_EN to also display transmitted bytes (TX path, pending register, S_TX).
//
// state  | meaning
// S_BAUD | showing {6'b0, baud_q}, mode = BAUDRATE_MODE
// S_RX   | showing received byte, hold counter running
// S_TX   | showing transmitted byte, hold counter running (DISP_TX_ECHO_EN only)
module display_msg_sel #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input logic              src_clk,
  input logic              rst_n,
  display_msg_sel_if.slave bus
);

  localparam logic [1:0] S_BAUD = 2'b00;
  localparam logic [1:0] S_RX   = 2'b01;
  localparam logic       BAUDRATE_MODE = 1'b0;
  localparam logic       DATA_MODE     = 1'b1;
  localparam logic [1:0] SRC_BAUD = 2'b00;
  localparam logic [1:0] SRC_RX   = 2'b01;
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
`ifdef DISP_TX_ECHO_EN
  localparam logic [1:0] S_TX   = 2'b10;
  localparam logic [1:0] SRC_TX = 2'b10;
`endif

  logic [1:0]       state;
  logic [1:0]       baud_q;
  logic             mode_q;
  logic [7:0]       msg_q;
  logic [1:0]       show_src_q;
  logic [CNT_W-1:0] cnt;
  logic             baud_chg;

`ifdef DISP_TX_ECHO_EN
  logic       pend;
  logic [7:0] pend_byte;
`else
  logic unused_tx;
  assign unused_tx = ^{bus.tx_start, bus.tx_data};
`endif

  assign baud_chg = (bus.baud_sel != baud_q);

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_BAUD;
      baud_q     <= 2'b00;
      mode_q     <= BAUDRATE_MODE;
      msg_q      <= 8'h00;
      show_src_q <= SRC_BAUD;
      cnt        <= '0;
`ifdef DISP_TX_ECHO_EN
      pend       <= 1'b0;
      pend_byte  <= 8'h00;
`endif
    end else begin
      baud_q <= bus.baud_sel;
      if (baud_chg) begin
        // a baud change wins outright; strobes in the same cycle are dropped
        state      <= S_BAUD;
        mode_q     <= BAUDRATE_MODE;
        msg_q      <= {6'b0, bus.baud_sel};
        show_src_q <= SRC_BAUD;
        cnt        <= '0;
`ifdef DISP_TX_ECHO_EN
        pend       <= 1'b0;
`endif
      end else if (bus.rx_valid) begin
        state      <= S_RX;
        mode_q     <= DATA_MODE;
        msg_q      <= bus.rx_data;
        show_src_q <= SRC_RX;
        cnt        <= HOLD_LD;
`ifdef DISP_TX_ECHO_EN
        if (bus.tx_start) begin
          pend      <= 1'b1;
          pend_byte <= bus.tx_data;
        end
`endif
      end
`ifdef DISP_TX_ECHO_EN
      else if (bus.tx_start && (state == S_RX)) begin
        // RX keeps the display; TX waits its turn and the hold keeps running
        pend      <= 1'b1;
        pend_byte <= bus.tx_data;
        if (cnt != '0) cnt <= cnt - CNT_W'(1);
      end else if (bus.tx_start && ((state == S_BAUD) || (state == S_TX))) begin
        state      <= S_TX;
        mode_q     <= DATA_MODE;
        msg_q      <= bus.tx_data;
        show_src_q <= SRC_TX;
        cnt        <= HOLD_LD;
      end
`endif
      else begin
        case (state)
`ifdef DISP_TX_ECHO_EN
          S_RX, S_TX: begin
`else
          S_RX: begin
`endif
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end
`ifdef DISP_TX_ECHO_EN
            else if (pend) begin
              state      <= S_TX;
              mode_q     <= DATA_MODE;
              msg_q      <= pend_byte;
              show_src_q <= SRC_TX;
              cnt        <= HOLD_LD;
              pend       <= 1'b0;
            end
`endif
            else begin
              state      <= S_BAUD;
              mode_q     <= BAUDRATE_MODE;
              msg_q      <= {6'b0, baud_q};
              show_src_q <= SRC_BAUD;
            end
          end
          default: begin
            state      <= S_BAUD;
            mode_q     <= BAUDRATE_MODE;
            msg_q      <= {6'b0, baud_q};
            show_src_q <= SRC_BAUD;
            cnt        <= '0;
          end
        endcase
      end
    end
  end

  assign bus.mode     = mode_q;
  assign bus.msg      = msg_q;
  assign bus.show_src = show_src_q;

endmodule

// File: tb/tb_display_msg_sel.sv
// Directed bench for display_msg_sel with HOLD_CYCLES=4; adapts TX cases to DISP_TX_ECHO_EN.
module tb_display_msg_sel;

  localparam logic [1:0] SEL_9600   = 2'b00;
  localparam logic [1:0] SEL_57600  = 2'b01;
  localparam logic [1:0] SEL_115200 = 2'b10;
  localparam logic BAUD_M = 1'b0;
  localparam logic DATA_M = 1'b1;

  logic src_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   errs    = 0;
  int   checks  = 0;

  display_msg_sel_if bus ();

  display_msg_sel #(.HOLD_CYCLES(4), .CNT_W(3)) dut (
    .src_clk (src_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 src_clk = ~src_clk;

  task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got mode/msg/src=%b/%h/%b want %b/%h/%b",
               tag, got[10], got[9:2], got[1:0], exp[10], exp[9:2], exp[1:0]);
    end
  endtask

  task automatic chk_out(input string tag, input logic m, input logic [7:0] d, input logic [1:0] s);
    chk(tag, {bus.mode, bus.msg, bus.show_src}, {m, d, s});
  endtask

  task automatic pulse_rx(input logic [7:0] d);
    bus.rx_valid = 1'b1;
    bus.rx_data  = d;
    @(negedge src_clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_tx(input logic [7:0] d);
    bus.tx_start = 1'b1;
    bus.tx_data  = d;
    @(negedge src_clk);
    bus.tx_start = 1'b0;
  endtask

  initial begin
    bus.baud_sel = SEL_115200;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;

    @(negedge src_clk);
    chk_out("reset", BAUD_M, 8'h00, 2'b00);
    rst_n = 1'b1;
    @(negedge src_clk);
    chk_out("baud_after_reset", BAUD_M, {6'b0, SEL_115200}, 2'b00);

    // single RX: exactly 4 cycles of data, then baud
    pulse_rx(8'h41);
    for (int i = 0; i < 4; i++) begin
      chk_out("rx_hold", DATA_M, 8'h41, 2'b01);
      if (i < 3) @(negedge src_clk);
    end
    @(negedge src_clk);
    chk_out("rx_end", BAUD_M, {6'b0, SEL_115200}, 2'b00);

    // simultaneous strobes
    bus.tx_start = 1'b1;
    bus.tx_data  = 8'h32;
    pulse_rx(8'h31);
    bus.tx_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_out("simul_rx", DATA_M, 8'h31, 2'b01);
      @(negedge src_clk);
    end
`ifdef DISP_TX_ECHO_EN
    for (int i = 0; i < 4; i++) begin
      chk_out("simul_tx", DATA_M, 8'h32, 2'b10);
      @(negedge src_clk);
    end
`endif
    chk_out("simul_end", BAUD_M, {6'b0, SEL_115200}, 2'b00);

    // RX retrigger two cycles later: 6 data cycles in total
    pulse_rx(8'h55);
    chk_out("retrig_first", DATA_M, 8'h55, 2'b01);
    @(negedge src_clk);
    chk_out("retrig_first2", DATA_M, 8'h55, 2'b01);
    pulse_rx(8'hAA);
    for (int i = 0; i < 4; i++) begin
      chk_out("retrig_second", DATA_M, 8'hAA, 2'b01);
      @(negedge src_clk);
    end
    chk_out("retrig_end", BAUD_M, {6'b0, SEL_115200}, 2'b00);

    // baud change mid-hold with a TX pending; pending byte must never appear
    pulse_rx(8'h77);
    pulse_tx(8'h88);
    chk_out("pend_rx", DATA_M, 8'h77, 2'b01);
    bus.baud_sel = SEL_57600;
    @(negedge src_clk);
    chk_out("baud_chg", BAUD_M, {6'b0, SEL_57600}, 2'b00);
    for (int i = 0; i < 8; i++) begin
      @(negedge src_clk);
      chk_out("pend_dropped", BAUD_M, {6'b0, SEL_57600}, 2'b00);
    end

`ifdef DISP_TX_ECHO_EN
    // TX from baud view shows immediately; TX in S_TX restarts with new byte
    pulse_tx(8'h99);
    chk_out("tx_show", DATA_M, 8'h99, 2'b10);
    pulse_tx(8'h9A);
    chk_out("tx_retrig", DATA_M, 8'h9A, 2'b10);
`else
    pulse_tx(8'h99);
    chk_out("tx_ignored", BAUD_M, {6'b0, SEL_57600}, 2'b00);
    pulse_rx(8'h9A);
    chk_out("rx_show", DATA_M, 8'h9A, 2'b01);
`endif

    // async reset between edges during the hold
    #2 rst_n = 1'b0;
    #1 chk_out("async_reset", BAUD_M, 8'h00, 2'b00);
    @(negedge src_clk);
    chk_out("reset_held", BAUD_M, 8'h00, 2'b00);
    rst_n = 1'b1;
    @(negedge src_clk);
    chk_out("baud_q_reset", BAUD_M, {6'b0, SEL_57600}, 2'b00);

    bus.baud_sel = SEL_9600;
    @(negedge src_clk);
    chk_out("baud_9600", BAUD_M, {6'b0, SEL_9600}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/display_msg_sel.md
# display_msg_sel

Upstream feeder for the seven-segment digit display stage: generates that stage's `mode` and `msg` inputs. It shows the current baud-rate selection by default. When a UART byte is received or transmitted, it shows that byte for a fixed hold time, then returns to the baud view. It sits between the UART RX/TX cores plus the baud selector and the digit display.

## Interface
Parameters:
- `HOLD_CYCLES`, default 50_000_000: number of cycles a data byte stays displayed (1 s at 50 MHz); must be ≥ 2.
- `CNT_W`, default 26: hold counter width; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- `src_clk`  input  1  single clock; all logic on its rising edge.
- `rst_n`  input  1  reset; **asynchronous, active-low**.
- `baud_sel`  input  2  baud selection code (`SEL_9600`/`SEL_57600`/`SEL_115200` from common.v); level, quasi-static.
- `rx_valid`  input  1  one-cycle strobe; `rx_data` is valid.
- `rx_data`  input  8  received byte.
- `tx_start`  input  1  one-cycle strobe; `tx_data` is accepted by the TX core.
- `tx_data`  input  8  transmitted byte.
- `mode`  output  1  `BAUDRATE_MODE` or `DATA_MODE` (common.v); registered.
- `msg`  output  8  baud code (`{6'b0, baud_sel}`) or data byte; registered.
- `show_src`  output  2  what is shown: 00 = baud, 01 = RX, 10 = TX; registered.

## Operation
- **Reset values:** `mode=BAUDRATE_MODE`, `msg=8'h00`, `show_src=2'b00`, state `S_BAUD`, `baud_q=2'b00`, hold counter = 0, pending flag = 0, pending byte = 0.
- **S_BAUD:**
  - Outputs `{6'b0, baud_q}` with `mode=BAUDRATE_MODE`.
  - `baud_q` registers `baud_sel` every cycle.
- **Baud change** (`baud_sel != baud_q`):
  - Highest priority, in any state.
  - Go to `S_BAUD`, show the new code, clear the pending flag.
  - Any RX/TX strobe in that same cycle is dropped.
- **RX event** (`rx_valid`, no baud change):
  - Latch `rx_data` into `msg`, set `mode=DATA_MODE`, `show_src=01`.
  - Enter `S_RX` and load the counter with `HOLD_CYCLES-1`.
  - A new RX while in `S_RX` or `S_TX` replaces the shown byte immediately and restarts the counter.
- **TX event** (`tx_start`, no RX and no baud change in the same cycle):
  - In `S_BAUD`, or in `S_TX`, show it immediately: `S_TX`, `show_src=10`, counter reloaded.
  - In `S_RX`, store it as pending (flag=1). A later pending TX overwrites the earlier one.
- **Simultaneous `rx_valid` and `tx_start`:** RX is shown; the TX byte goes to pending.
- **Counter:**
  - Decrements by 1 per cycle in `S_RX`/`S_TX`.
  - At 0 with no event: if pending, show the pending byte as TX (`S_TX`, counter reloaded, flag cleared); else return to `S_BAUD`.
- **State machine** (2-bit state, `S_BAUD` → `S_RX`/`S_TX` → `S_BAUD`):
  - `S_RX` → `S_TX` only via pending.
  - `S_TX` → `S_RX` on an RX event.
  - Any state → `S_BAUD` on a baud change.
  - Unused encoding → `S_BAUD`.
- **Width rule:** counter compare is against `CNT_W'(HOLD_CYCLES-1)`; there is no wrap, because the counter is never decremented at 0.

## Timing
- Latency: a strobe sampled at edge k appears on `mode`/`msg`/`show_src` right after edge k (1 cycle). A baud change is likewise visible 1 cycle after it is sampled.
- A data byte is displayed for exactly `HOLD_CYCLES` cycles when not interrupted. The baud view (or pending TX) appears on edge k+`HOLD_CYCLES`.
- Reset assertion mid-hold forces the reset values immediately, with no clock. Deassertion must be synchronous to `src_clk` (external synchronizer).
- Strobes are single-cycle; a strobe held high for n cycles counts as n events.

## Configuration
- `DISP_TX_ECHO_EN` defined:
  - TX path, pending register and `S_TX` are compiled in, as described above.
- Undefined:
  - `tx_start` and `tx_data` are ignored and no pending logic exists.
  - `show_src` is never 10; the `S_TX` encoding decodes to `S_BAUD`.
  - Only RX bytes are displayed.

## Test plan
Bench uses `HOLD_CYCLES=4`.
- **Reset, then baud change:** reset with `baud_sel=SEL_115200` → after release, 1 cycle later `mode=BAUDRATE_MODE`, `msg={6'b0,SEL_115200}`, `show_src=00`.
- **Single RX:** `rx_valid` with `rx_data=8'h41` → `msg=8'h41`, `mode=DATA_MODE`, `show_src=01` for exactly 4 cycles, then back to the baud code.
- **Simultaneous strobes** (`DISP_TX_ECHO_EN`): `rx_valid` with 8'h31 and `tx_start` with 8'h32 in the same cycle → 8'h31/`show_src=01` for 4 cycles, then 8'h32/`show_src=10` for 4 cycles, then baud.
- **RX retrigger:** RX 8'h55, then RX 8'hAA two cycles later → 8'hAA is shown from the next edge for 4 full cycles; total data time is 6 cycles.
- **Baud change mid-hold with pending TX:** while showing RX with a TX pending, change `baud_sel` → the next cycle shows the baud code, and the pending TX is never displayed.
- **Async reset mid-hold:** assert `rst_n=0` between edges during `S_TX` → outputs return to the reset values immediately, with no clock edge.
